// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN timestep scheduler.
// Status-bit positions match the config-register read mux.
package snn_pkg;

  localparam int SNN_STEP_W = 32;

  localparam int STAT_BUSY_BIT    = 0;
  localparam int STAT_DONE_BIT    = 1;
  localparam int STAT_CFG_ERR_BIT = 2;
  localparam int STAT_TMO_ERR_BIT = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SPIKE,
    S_LSTART,
    S_LWAIT,
    S_STEP_END
  } sched_state_t;

endpackage

// File: rtl/snn_timestep_scheduler_watchdog.sv
// Per-layer watchdog: loaded on layer start, counts while waiting.
// Built only when SNN_SCHED_TIMEOUT_EN is defined.
module snn_sched_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int W = $clog2(LIMIT + 1) + 1;

  logic [W-1:0] cnt_q;

  // Load with 1 so the layer-start cycle counts toward the limit.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= W'(1);
    end else if (en_i && !expire_o) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign expire_o = en_i && (cnt_q >= W'(LIMIT - 1));

endmodule

// File: rtl/snn_timestep_scheduler.sv
// Inference-run sequencer: clear, then per timestep spike-advance and layers.
// Optional per-layer watchdog enabled by SNN_SCHED_TIMEOUT_EN.
module snn_timestep_scheduler
  import snn_pkg::*;
#(
  parameter int NUM_LAYERS     = 2,
  parameter int STEP_W         = SNN_STEP_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  input  logic                  start,
  input  logic                  stop,
  input  logic [STEP_W-1:0]     num_steps,
  input  logic                  mem_sel,
  input  logic [NUM_LAYERS-1:0] layer_done,
  output logic                  neuron_clr,
  output logic                  spike_step,
  output logic [NUM_LAYERS-1:0] layer_start,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic                  timeout_err,
  output logic [STEP_W-1:0]     step_count
);

  localparam int IW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_LAYERS - 1);

  sched_state_t          state_q;
  logic [IW-1:0]         idx_q;
  logic [STEP_W-1:0]     steps_q;
  logic [STEP_W-1:0]     cnt_q;
  logic [STEP_W-1:0]     cnt_d;
  logic [NUM_LAYERS-1:0] ls_q;
  logic                  clr_q;
  logic                  spk_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  cfg_q;
  logic                  tmo_q;
  logic                  wd_expire;

  assign cnt_d = cnt_q + STEP_W'(1);

`ifdef SNN_SCHED_TIMEOUT_EN
  snn_sched_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_wd (
    .clk_i   (S_AXI_ACLK),
    .rst_ni  (S_AXI_ARESETN),
    .load_i  (state_q == S_LSTART),
    .en_i    (state_q == S_LWAIT),
    .expire_o(wd_expire)
  );
`else
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      steps_q <= '0;
      cnt_q   <= '0;
      ls_q    <= '0;
      clr_q   <= 1'b0;
      spk_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cfg_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      clr_q <= 1'b0;
      spk_q <= 1'b0;
      ls_q  <= '0;
      if (state_q != S_IDLE && stop) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start && !stop) begin
              if (mem_sel) begin
                cfg_q <= 1'b1;
              end else if (num_steps == '0) begin
                done_q <= 1'b1;
              end else begin
                steps_q <= num_steps;
                cnt_q   <= '0;
                done_q  <= 1'b0;
                cfg_q   <= 1'b0;
                tmo_q   <= 1'b0;
                busy_q  <= 1'b1;
                clr_q   <= 1'b1;
                state_q <= S_CLEAR;
              end
            end
          end
          S_CLEAR: begin
            spk_q   <= 1'b1;
            state_q <= S_SPIKE;
          end
          S_SPIKE: begin
            idx_q   <= '0;
            ls_q    <= NUM_LAYERS'(1);
            state_q <= S_LSTART;
          end
          S_LSTART: begin
            state_q <= S_LWAIT;
          end
          S_LWAIT: begin
            if (layer_done[idx_q]) begin
              if (idx_q == LAST) begin
                state_q <= S_STEP_END;
              end else begin
                idx_q   <= idx_q + IW'(1);
                ls_q    <= NUM_LAYERS'(1) << (idx_q + IW'(1));
                state_q <= S_LSTART;
              end
            end else if (wd_expire) begin
              tmo_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end
          S_STEP_END: begin
            cnt_q <= cnt_d;
            if (cnt_d == steps_q) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              spk_q   <= 1'b1;
              state_q <= S_SPIKE;
            end
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign neuron_clr  = clr_q;
  assign spike_step  = spk_q;
  assign layer_start = ls_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cfg_err     = cfg_q;
  assign timeout_err = tmo_q;
  assign step_count  = cnt_q;

endmodule

// File: tb/tb_snn_timestep_scheduler.sv
// Self-checking bench for snn_timestep_scheduler (NUM_LAYERS=2).
// Vector table plus directed multi-cycle sequences.
module tb_snn_timestep_scheduler;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start_r;
  logic        stop_r;
  logic [31:0] ns_r;
  logic        msel_r;
  logic [1:0]  ld_r;
  logic        clr, spk, busy, done, cfg, terr;
  logic [1:0]  ls;
  logic [31:0] cnt;
  logic [15:0] outs;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  snn_timestep_scheduler #(
    .NUM_LAYERS    (2),
    .STEP_W        (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rstn),
    .start        (start_r),
    .stop         (stop_r),
    .num_steps    (ns_r),
    .mem_sel      (msel_r),
    .layer_done   (ld_r),
    .neuron_clr   (clr),
    .spike_step   (spk),
    .layer_start  (ls),
    .busy         (busy),
    .done         (done),
    .cfg_err      (cfg),
    .timeout_err  (terr),
    .step_count   (cnt)
  );

  assign outs = {clr, spk, ls, busy, done, cfg, terr, cnt[7:0]};

  typedef struct {
    logic        rstn;
    logic        start;
    logic        stop;
    logic        msel;
    logic [7:0]  ns;
    logic [1:0]  ld;
    logic [15:0] exp;
  } vec_t;

  vec_t vt[15];

  function automatic logic [15:0] ov(
    input logic c, input logic s, input logic [1:0] l,
    input logic b, input logic d, input logic e,
    input logic [7:0] n);
    return {c, s, l, b, d, e, 1'b0, n};
  endfunction

  function automatic vec_t mk(
    input logic r, input logic st, input logic sp, input logic m,
    input logic [7:0] n, input logic [1:0] l, input logic [15:0] e);
    vec_t v;
    v.rstn = r; v.start = st; v.stop = sp; v.msel = m;
    v.ns = n; v.ld = l; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    start_r = 1'b0; stop_r = 1'b0; msel_r = 1'b0;
  endtask

  task automatic wait_cnt(input int target, input int budget);
    int k;
    k = 0;
    while (cnt != 32'(target) && k < budget) begin
      tick();
      k++;
    end
    chk("wait_step_count", cnt, 64'(target));
  endtask

  initial begin
    logic [31:0] spk_m, ls0_m, ls1_m;
    int done_k;
    rstn = 1'b0; start_r = 1'b0; stop_r = 1'b0;
    ns_r = '0; msel_r = 1'b0; ld_r = '0;

    vt[0]  = mk(0, 0, 0, 0, 1, 0, ov(0, 0, 0, 0, 0, 0, 0));
    vt[1]  = mk(1, 0, 0, 0, 1, 0, ov(0, 0, 0, 0, 0, 0, 0));
    vt[2]  = mk(1, 1, 0, 1, 1, 0, ov(0, 0, 0, 0, 0, 1, 0));
    vt[3]  = mk(1, 0, 0, 0, 1, 0, ov(0, 0, 0, 0, 0, 1, 0));
    vt[4]  = mk(1, 1, 1, 0, 1, 0, ov(0, 0, 0, 0, 0, 1, 0));
    vt[5]  = mk(1, 1, 0, 0, 0, 0, ov(0, 0, 0, 0, 1, 1, 0));
    vt[6]  = mk(1, 1, 0, 0, 1, 3, ov(1, 0, 0, 1, 0, 0, 0));
    vt[7]  = mk(1, 1, 0, 0, 5, 3, ov(0, 1, 0, 1, 0, 0, 0));
    vt[8]  = mk(1, 0, 0, 1, 5, 3, ov(0, 0, 1, 1, 0, 0, 0));
    vt[9]  = mk(1, 0, 0, 0, 5, 3, ov(0, 0, 0, 1, 0, 0, 0));
    vt[10] = mk(1, 0, 0, 0, 5, 3, ov(0, 0, 2, 1, 0, 0, 0));
    vt[11] = mk(1, 0, 0, 0, 5, 3, ov(0, 0, 0, 1, 0, 0, 0));
    vt[12] = mk(1, 0, 0, 0, 5, 3, ov(0, 0, 0, 1, 0, 0, 0));
    vt[13] = mk(1, 0, 0, 0, 5, 3, ov(0, 0, 0, 0, 1, 0, 1));
    vt[14] = mk(1, 0, 1, 0, 5, 3, ov(0, 0, 0, 0, 1, 0, 1));

    #2;
    for (int i = 0; i < 15; i++) begin
      rstn    = vt[i].rstn;
      start_r = vt[i].start;
      stop_r  = vt[i].stop;
      msel_r  = vt[i].msel;
      ns_r    = 32'(vt[i].ns);
      ld_r    = vt[i].ld;
      tick();
      chk($sformatf("vec%0d", i), outs, vt[i].exp);
    end
    idle_in();

    // Three steps, zero-latency layers
    ns_r = 3; ld_r = 2'b11; start_r = 1'b1;
    tick();
    start_r = 1'b0;
    chk("a_clear", {clr, busy}, 2'b11);
    spk_m = '0; ls0_m = '0; ls1_m = '0; done_k = -1;
    for (int k = 1; k < 30; k++) begin
      tick();
      if (spk) spk_m[k] = 1'b1;
      if (ls[0]) ls0_m[k] = 1'b1;
      if (ls[1]) ls1_m[k] = 1'b1;
      if (done && done_k < 0) done_k = k;
    end
    chk("a_spike_pos", spk_m, (32'd1 << 1) | (32'd1 << 7) | (32'd1 << 13));
    chk("a_ls0_pos", ls0_m, (32'd1 << 2) | (32'd1 << 8) | (32'd1 << 14));
    chk("a_ls1_pos", ls1_m, (32'd1 << 4) | (32'd1 << 10) | (32'd1 << 16));
    chk("a_done_cycle", 64'(done_k), 64'd19);
    chk("a_step_count", cnt, 32'd3);
    chk("a_busy_low", busy, 1'b0);

    // Only the active layer's done advances
    ns_r = 1; ld_r = 2'b00; start_r = 1'b1;
    tick();
    start_r = 1'b0;
    tick(); tick();
    chk("b_ls0", ls, 2'b01);
    tick();
    ld_r = 2'b01;
    tick();
    chk("b_ls1", ls, 2'b10);
    for (int k = 0; k < 5; k++) begin
      ld_r = {1'b0, 1'($urandom_range(1, 0))};
      tick();
      chk($sformatf("b_hold%0d", k), {ls, busy, done}, 4'b0010);
    end
    ld_r = 2'b10;
    tick();
    ld_r = 2'b00;
    chk("b_step_end", {busy, done}, 2'b10);
    tick();
    chk("b_done", {busy, done, cnt[7:0]}, {2'b01, 8'd1});

    // Abort after four steps
    ns_r = 10; ld_r = 2'b11; start_r = 1'b1;
    tick();
    start_r = 1'b0;
    wait_cnt(4, 200);
    stop_r = 1'b1;
    tick();
    stop_r = 1'b0;
    chk("c_stop", {busy, done, cnt[7:0]}, {2'b00, 8'd4});
    tick();
    chk("c_stop_hold", outs, ov(0, 0, 0, 0, 0, 0, 4));

    // Reset mid-run
    start_r = 1'b1;
    tick();
    start_r = 1'b0;
    wait_cnt(2, 200);
    rstn = 1'b0;
    tick();
    chk("c_reset", {outs, cnt}, 48'd0);
    rstn = 1'b1;

    // Watchdog behaviour with stalled layer
    ns_r = 1; ld_r = 2'b00; start_r = 1'b1;
    tick();
    start_r = 1'b0;
    tick(); tick();
    chk("d_ls0", ls, 2'b01);
    for (int k = 0; k < 7; k++) tick();
    chk("d_busy_e9", busy, 1'b1);
    tick();
`ifdef SNN_SCHED_TIMEOUT_EN
    chk("d_timeout", {busy, terr, done}, 3'b010);
`else
    chk("d_no_timeout", {busy, terr, done}, 3'b100);
    for (int k = 0; k < 20; k++) tick();
    chk("d_still_busy", {busy, terr}, 2'b10);
    stop_r = 1'b1;
    tick();
    stop_r = 1'b0;
    chk("d_stop", busy, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
